// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the stage sequencer: state encoding and the
// width helper used to size the memory-wait counter.
package stage_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } seq_state_t;

  localparam int WAIT_MAX_DFLT = 255;
  localparam int WAIT_W_DFLT   = $clog2(WAIT_MAX_DFLT + 1);

  // Width of a counter that must be able to hold the value wait_max.
  function automatic int wait_width(input int wait_max);
    return $clog2(wait_max + 1);
  endfunction

endpackage

// File: rtl/stage_sequencer_wait_timer.sv
// Memory wait timer shared by the FETCH and MEM waits.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_clear       : restart the count at zero (entry into a wait state)
//   i_enable      : count this cycle (sequencer sits in a wait state)
//   o_expired     : count has reached WAIT_MAX
module stage_sequencer_wait_timer
  import stage_sequencer_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int                WAIT_W = wait_width(WAIT_MAX);
  localparam logic [WAIT_W-1:0] LIMIT  = WAIT_W'(WAIT_MAX);

  logic [WAIT_W-1:0] r_count;

  // Wait counter: zero in the entry cycle, then one higher per cycle spent
  // waiting; it holds at LIMIT so it can never wrap back below it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + WAIT_W'(1);
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle control sequencer for the RV32IM core. Steps each instruction
// through FETCH, DECODE, EXEC, MEM (loads/stores only) and WB, emitting a
// one-cycle registered enable on entry to each stage, and keeps the 64-bit
// cycle/instret counters.
// Ports:
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_start                      : begin/resume (IDLE or HALT only)
//   i_halt_req                   : stop at the next WB
//   i_instr_ready, i_mem_ready   : memory handshakes
//   i_is_load/store/muldiv       : decoded instruction class
//   i_muldiv_done                : iterative mul/div result valid
//   o_*_enabled                  : stage enable pulses
//   o_busy, o_halted, o_bus_error: status (bus_error sticky until reset)
//   o_cycle, o_instret           : performance counters
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_halt_req,
  input  logic             i_instr_ready,
  input  logic             i_mem_ready,
  input  logic             i_is_load,
  input  logic             i_is_store,
  input  logic             i_is_muldiv,
  input  logic             i_muldiv_done,
  output logic             o_fetch_enabled,
  output logic             o_decode_enabled,
  output logic             o_exec_enabled,
  output logic             o_mem_enabled,
  output logic             o_wb_enabled,
  output logic             o_busy,
  output logic             o_halted,
  output logic             o_bus_error,
  output logic [CNT_W-1:0] o_cycle,
  output logic [CNT_W-1:0] o_instret
);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic             w_timeout;
  logic             w_expired;
  logic             w_wait_clear;
  logic             w_wait_en;
  logic             r_fetch_en;
  logic             r_decode_en;
  logic             r_exec_en;
  logic             r_mem_en;
  logic             r_wb_en;
  logic             r_busy;
  logic             r_halted;
  logic             r_bus_error;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instret;

  // The entry-cycle enable doubles as the "first cycle" flag, so handshakes
  // seen in the entry cycle of FETCH/EXEC/MEM are ignored.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_FETCH;
        else         w_next = S_IDLE;
      end
      S_FETCH: begin
        if (r_fetch_en) begin
          w_next = S_FETCH;
        end else if (i_instr_ready) begin
          w_next = S_DECODE;
        end else if (w_expired) begin
          w_next    = S_HALT;
          w_timeout = 1'b1;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (i_is_muldiv && (r_exec_en || !i_muldiv_done)) w_next = S_EXEC;
        else if (i_is_load || i_is_store)                  w_next = S_MEM;
        else                                               w_next = S_WB;
      end
      S_MEM: begin
        if (r_mem_en) begin
          w_next = S_MEM;
        end else if (i_mem_ready) begin
          w_next = S_WB;
        end else if (w_expired) begin
          w_next    = S_HALT;
          w_timeout = 1'b1;
        end else begin
          w_next = S_MEM;
        end
      end
      S_WB: begin
        if (i_halt_req) w_next = S_HALT;
        else            w_next = S_FETCH;
      end
      S_HALT: begin
        if (i_start) w_next = S_FETCH;
        else         w_next = S_HALT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_wait_clear = ((w_next == S_FETCH) && (r_state != S_FETCH)) ||
                        ((w_next == S_MEM)   && (r_state != S_MEM));
  assign w_wait_en    = (r_state == S_FETCH) || (r_state == S_MEM);

  stage_sequencer_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_wait_clear),
    .i_enable  (w_wait_en),
    .o_expired (w_expired)
  );

  // State register and registered Moore outputs, decoded from the state
  // being entered so each enable lines up with its state's first cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_fetch_en  <= 1'b0;
      r_decode_en <= 1'b0;
      r_exec_en   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_wb_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_fetch_en  <= (w_next == S_FETCH) && (r_state != S_FETCH);
      r_decode_en <= (w_next == S_DECODE);
      r_exec_en   <= (w_next == S_EXEC) && (r_state != S_EXEC);
      r_mem_en    <= (w_next == S_MEM) && (r_state != S_MEM);
      r_wb_en     <= (w_next == S_WB);
      r_busy      <= (w_next != S_IDLE) && (w_next != S_HALT);
      r_halted    <= (w_next == S_HALT);
      r_bus_error <= r_bus_error | w_timeout;
    end
  end

  // Cycle and retired-instruction counters; both wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle <= r_cycle + CNT_W'(1);
      if (r_state == S_WB) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign o_fetch_enabled  = r_fetch_en;
  assign o_decode_enabled = r_decode_en;
  assign o_exec_enabled   = r_exec_en;
  assign o_mem_enabled    = r_mem_en;
  assign o_wb_enabled     = r_wb_en;
  assign o_busy           = r_busy;
  assign o_halted         = r_halted;
  assign o_bus_error      = r_bus_error;
  assign o_cycle          = r_cycle;
  assign o_instret        = r_instret;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer. Each instruction is described by
// its handshake delays; the expected stage timeline is computed from those
// delays with plain arithmetic and compared every cycle.
module tb_stage_sequencer;

  localparam int WM = 4;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, instr_ready, mem_ready;
  logic        is_load, is_store, is_muldiv, muldiv_done;
  logic        fe, de, ee, me, we, busy, halted, berr;
  logic [63:0] cyc, iret;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_cycle = 64'd0;
  logic [63:0] exp_iret  = 64'd0;
  logic        exp_berr  = 1'b0;

  always #5 clk = ~clk;

  stage_sequencer #(.WAIT_MAX(WM), .CNT_W(64)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_halt_req(halt_req),
    .i_instr_ready(instr_ready), .i_mem_ready(mem_ready),
    .i_is_load(is_load), .i_is_store(is_store), .i_is_muldiv(is_muldiv),
    .i_muldiv_done(muldiv_done),
    .o_fetch_enabled(fe), .o_decode_enabled(de), .o_exec_enabled(ee),
    .o_mem_enabled(me), .o_wb_enabled(we), .o_busy(busy), .o_halted(halted),
    .o_bus_error(berr), .o_cycle(cyc), .o_instret(iret)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) exp_cycle = 64'd0;
    else     exp_cycle = exp_cycle + 64'd1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_out(input logic f, input logic d, input logic e, input logic m,
                         input logic w, input logic b, input logic h);
    chk1("fetch_enabled", fe, f);
    chk1("decode_enabled", de, d);
    chk1("exec_enabled", ee, e);
    chk1("mem_enabled", me, m);
    chk1("wb_enabled", we, w);
    chk1("busy", busy, b);
    chk1("halted", halted, h);
    chk1("bus_error", berr, exp_berr);
    chk64("cycle", cyc, exp_cycle);
    chk64("instret", iret, exp_iret);
  endtask

  // Called in the cycle where fetch_enabled is expected (k = 0).
  // kind: 0 ALU, 1 load, 2 store, 3 mul/div. df/dm/dd: cycles after entry
  // of FETCH/EXEC/MEM at which the handshake is given. glitch adds a
  // handshake in the entry cycle, which must be ignored.
  task automatic run_instr(input int df, input bit glitch, input int kind,
                           input int dm, input int dd, input bit hreq,
                           output bit went_halt);
    bit ld, st, md, has_mem, to;
    int de_k, ee_k, me_k, we_k, last;
    ld = (kind == 1); st = (kind == 2); md = (kind == 3);
    has_mem = ld | st;
    de_k = df + 1;
    ee_k = df + 2;
    me_k = ee_k + (md ? dm + 1 : 1);
    we_k = has_mem ? me_k + dd + 1 : me_k;
    if (df > WM) begin
      to = 1'b1; last = WM;
    end else if (has_mem && dd > WM) begin
      to = 1'b1; last = me_k + WM;
    end else begin
      to = 1'b0; last = we_k;
    end
    for (int k = 0; k <= last; k++) begin
      chk_out(k == 0, k == de_k, k == ee_k, has_mem && k == me_k, k == we_k, 1'b1, 1'b0);
      instr_ready = (k == df) || (k == 0 && glitch);
      muldiv_done = md && ((k == ee_k + dm) || (k == ee_k && glitch));
      mem_ready   = has_mem && ((k == me_k + dd) || (k == me_k && glitch));
      is_load = ld; is_store = st; is_muldiv = md;
      halt_req = hreq;
      start = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0; instr_ready = 1'b0; mem_ready = 1'b0; muldiv_done = 1'b0;
    if (to) exp_berr = 1'b1;
    else    exp_iret = exp_iret + 64'd1;
    went_halt = to | hreq;
    if (went_halt) chk_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Sit in HALT with halt_req high (ignored), then restart with start.
  task automatic resume();
    for (int i = 0; i < 2; i++) begin
      halt_req = 1'b1; start = 1'b0;
      tick();
      chk_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    bit hlt;
    int df, kind, dm, dd;
    bit gl, hq;
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; instr_ready = 1'b0;
    mem_ready = 1'b0; is_load = 1'b0; is_store = 1'b0; is_muldiv = 1'b0;
    muldiv_done = 1'b0;
    tick();
    tick();
    chk_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // start and halt_req together in IDLE: start wins, halt at first WB
    start = 1'b1; halt_req = 1'b1;
    tick();
    start = 1'b0;
    run_instr(1, 1'b0, 0, 0, 0, 1'b1, hlt);
    resume();
    // ALU, load with mem_ready 3 cycles late, mul/div taking 33 cycles
    run_instr(1, 1'b1, 0, 0, 0, 1'b0, hlt);
    run_instr(1, 1'b0, 1, 0, 3, 1'b0, hlt);
    run_instr(2, 1'b1, 3, 33, 0, 1'b0, hlt);
    // halt request taken at WB
    run_instr(2, 1'b0, 0, 0, 0, 1'b1, hlt);
    resume();
    // fetch timeout, then resume with bus_error still set
    run_instr(WM + 1, 1'b1, 0, 0, 0, 1'b0, hlt);
    resume();
    // ready in the very cycle the wait limit is reached wins
    run_instr(WM, 1'b0, 2, 0, WM, 1'b0, hlt);
    // memory timeout
    run_instr(1, 1'b0, 1, 0, WM + 1, 1'b0, hlt);
    resume();

    for (int n = 0; n < 40; n++) begin
      df   = ($urandom_range(0, 9) == 0) ? WM + 1 : int'($urandom_range(1, WM));
      kind = int'($urandom_range(0, 3));
      dm   = int'($urandom_range(1, 12));
      dd   = ($urandom_range(0, 7) == 0) ? WM + 1 : int'($urandom_range(1, WM));
      gl   = 1'($urandom_range(0, 1));
      hq   = ($urandom_range(0, 4) == 0) || (n == 39);
      run_instr(df, gl, kind, dm, dd, hq, hlt);
      if (hlt && n != 39) resume();
    end

    // reset in the middle of a memory wait
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      chk_out(k == 0, k == 2, k == 3, k == 4, 1'b0, 1'b1, 1'b0);
      instr_ready = (k == 1); is_load = 1'b1; is_store = 1'b0; is_muldiv = 1'b0;
      halt_req = 1'b0;
      tick();
    end
    instr_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_iret = 64'd0; exp_berr = 1'b0;
    chk_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
